// File: rtl/vga_if.sv
// VGA timing and colour bundle passed between the pixel pipeline stages.
interface vga_if;
  logic [10:0] vcount;
  logic        vsync;
  logic        vblnk;
  logic [10:0] hcount;
  logic        hsync;
  logic        hblnk;
  logic [11:0] rgb;

  modport in  (input  vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
  modport out (output vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
endinterface

// File: rtl/platform_layer.sv
// Tiled platform overlay: up to N_PLAT horizontal platforms from a shared tile ROM,
// double-buffered descriptors swapped at vblnk rise, colour-key transparency, 3-cycle latency.
module platform_layer #(
  parameter int unsigned N_PLAT    = 8,
  parameter int unsigned TW_LOG2   = 6,
  parameter int unsigned TH_LOG2   = 5,
  parameter logic [11:0] KEY_RGB   = 12'hF0F,
  parameter logic [11:0] BLANK_RGB = 12'h888
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start_game,
  input  logic                       cfg_we,
  input  logic [3:0]                 cfg_idx,
  input  logic [38:0]                cfg_data,
  input  logic [11:0]                rgb_pixel,
  output logic [TH_LOG2+TW_LOG2-1:0] pixel_addr,
  vga_if.in                          in,
  vga_if.out                         out
);

  localparam int unsigned AW = TH_LOG2 + TW_LOG2;

  typedef struct packed {
    logic        en;
    logic [4:0]  row_off;
    logic [10:0] y_top;
    logic [10:0] x_start;
    logic [10:0] x_end;
  } slot_t;

  typedef struct packed {
    logic [10:0] vcount;
    logic        vsync;
    logic        vblnk;
    logic [10:0] hcount;
    logic        hsync;
    logic        hblnk;
    logic [11:0] rgb;
  } pix_t;

  slot_t shadow_q [N_PLAT];
  slot_t shadow_d [N_PLAT];
  slot_t active_q [N_PLAT];
  slot_t active_d [N_PLAT];
  logic  vblnk_prev_q;
  logic  vblnk_rise;

  assign vblnk_rise = in.vblnk & ~vblnk_prev_q;

  // Writes land in shadow first so a write on the swap cycle is copied through.
  always_comb begin
    shadow_d = shadow_q;
    if (cfg_we) begin
      for (int i = 0; i < int'(N_PLAT); i++) begin
        if (cfg_idx == 4'(i)) shadow_d[i] = slot_t'(cfg_data);
      end
    end
    if (vblnk_rise) active_d = shadow_d;
    else            active_d = active_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vblnk_prev_q <= 1'b0;
      for (int i = 0; i < int'(N_PLAT); i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      vblnk_prev_q <= in.vblnk;
      shadow_q     <= shadow_d;
      active_q     <= active_d;
    end
  end

  // Stage 0: per-slot hit test and tile coordinates.
  logic [N_PLAT-1:0]  hit_vec;
  logic [TH_LOG2-1:0] row_calc [N_PLAT];
  logic [TW_LOG2-1:0] col_calc [N_PLAT];
  logic               blank0;
  logic               hit0;
  logic [AW-1:0]      addr0;

  assign blank0 = in.hblnk | in.vblnk;

  always_comb begin
    for (int i = 0; i < int'(N_PLAT); i++) begin
      // 12-bit compare so a platform near the bottom never wraps to the top lines.
      hit_vec[i] = active_q[i].en & start_game & ~blank0 &
                   ({1'b0, in.vcount} >= {1'b0, active_q[i].y_top}) &
                   ({1'b0, in.vcount} < ({1'b0, active_q[i].y_top} + (12'd1 << TH_LOG2))) &
                   (in.hcount >= active_q[i].x_start) &
                   (in.hcount < active_q[i].x_end);
      row_calc[i] = TH_LOG2'(in.vcount - active_q[i].y_top + 11'(active_q[i].row_off));
      col_calc[i] = TW_LOG2'(in.hcount - active_q[i].x_start);
    end
  end

  // Descending scan so the lowest hitting index is the last assignment.
  always_comb begin
    hit0  = 1'b0;
    addr0 = '0;
    for (int i = int'(N_PLAT) - 1; i >= 0; i--) begin
      if (hit_vec[i]) begin
        hit0  = 1'b1;
        addr0 = {row_calc[i], col_calc[i]};
      end
    end
  end

  pix_t          pix0;
  pix_t          s1_q;
  pix_t          s2_q;
  pix_t          out_q;
  pix_t          out_d;
  logic          hit1_q;
  logic          hit2_q;
  logic [AW-1:0] pixel_addr_q;

  assign pix0 = '{vcount: in.vcount, vsync: in.vsync, vblnk: in.vblnk, hcount: in.hcount,
                  hsync: in.hsync, hblnk: in.hblnk, rgb: in.rgb};

  // Stage 3 decision; rgb_pixel is aligned with stage 2 contents.
  always_comb begin
    out_d = s2_q;
    if (s2_q.hblnk | s2_q.vblnk)             out_d.rgb = BLANK_RGB;
    else if (hit2_q && rgb_pixel != KEY_RGB) out_d.rgb = rgb_pixel;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q         <= '0;
      s2_q         <= '0;
      out_q        <= '0;
      hit1_q       <= 1'b0;
      hit2_q       <= 1'b0;
      pixel_addr_q <= '0;
    end else begin
      s1_q   <= pix0;
      hit1_q <= hit0;
      if (hit0) pixel_addr_q <= addr0;
      s2_q   <= s1_q;
      hit2_q <= hit1_q;
      out_q  <= out_d;
    end
  end

  assign pixel_addr = pixel_addr_q;
  assign out.vcount = out_q.vcount;
  assign out.vsync  = out_q.vsync;
  assign out.vblnk  = out_q.vblnk;
  assign out.hcount = out_q.hcount;
  assign out.hsync  = out_q.hsync;
  assign out.hblnk  = out_q.hblnk;
  assign out.rgb    = out_q.rgb;

endmodule

// File: tb/tb_platform_layer.sv
// Directed bench for platform_layer with a synchronous tile ROM model.
module tb_platform_layer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_game;
  logic        cfg_we;
  logic [3:0]  cfg_idx;
  logic [38:0] cfg_data;
  logic [11:0] rgb_pixel;
  logic [10:0] pixel_addr;
  logic        key_mode;
  int          errors = 0;
  int          checks = 0;

  vga_if vin ();
  vga_if vout ();

  platform_layer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_game (start_game),
    .cfg_we     (cfg_we),
    .cfg_idx    (cfg_idx),
    .cfg_data   (cfg_data),
    .rgb_pixel  (rgb_pixel),
    .pixel_addr (pixel_addr),
    .in         (vin),
    .out        (vout)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] rom_val(input logic [10:0] a);
    if (key_mode) return 12'hF0F;
    return {1'b0, a} + 12'h100;
  endfunction

  always @(posedge clk) rgb_pixel <= rom_val(pixel_addr);

  function automatic logic [38:0] mk(input logic en, input logic [4:0] ro,
                                     input logic [10:0] yt, input logic [10:0] xs,
                                     input logic [10:0] xe);
    return {en, ro, yt, xs, xe};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic step3();
    step(); step(); step();
  endtask

  task automatic set_pix(input logic [10:0] h, input logic [10:0] v, input logic hb,
                         input logic vb, input logic [11:0] rgb);
    vin.hcount = h;
    vin.vcount = v;
    vin.hblnk  = hb;
    vin.vblnk  = vb;
    vin.rgb    = rgb;
  endtask

  task automatic cfg_write(input logic [3:0] idx, input logic [38:0] data);
    cfg_idx  = idx;
    cfg_data = data;
    cfg_we   = 1'b1;
    step();
    cfg_we   = 1'b0;
  endtask

  task automatic frame_start();
    vin.vblnk = 1'b1;
    step();
    vin.vblnk = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start_game = 1'b0; cfg_we = 1'b0; cfg_idx = '0; cfg_data = '0;
    key_mode = 1'b0; vin.vsync = 1'b0; vin.hsync = 1'b0;
    set_pix(11'd7, 11'd7, 1'b0, 1'b0, 12'hFFF);
    step(); step();
    checks++; if (vout.rgb !== 12'h000) begin errors++; $display("FAIL reset_rgb: got %h exp %h", vout.rgb, 12'h000); end
    checks++; if (vout.hcount !== 11'd0) begin errors++; $display("FAIL reset_hcount: got %0d exp 0", vout.hcount); end
    checks++; if (pixel_addr !== 11'd0) begin errors++; $display("FAIL reset_addr: got %h exp 0", pixel_addr); end
    rst_n = 1'b1;
    start_game = 1'b1;
    set_pix(11'd20, 11'd20, 1'b0, 1'b0, 12'hABC);
    step3();
    checks++; if (vout.rgb !== 12'hABC) begin errors++; $display("FAIL pass_rgb: got %h exp %h", vout.rgb, 12'hABC); end
    checks++; if (vout.vcount !== 11'd20) begin errors++; $display("FAIL pass_vcount: got %0d exp 20", vout.vcount); end
  endtask

  task automatic test_basic();
    cfg_write(4'd0, mk(1'b1, 5'd0, 11'd568, 11'd0, 11'd512));
    frame_start();
    set_pix(11'd5, 11'd570, 1'b0, 1'b0, 12'h321);
    step();
    checks++; if (pixel_addr !== 11'd133) begin errors++; $display("FAIL basic_addr: got %0d exp 133", pixel_addr); end
    step(); step();
    checks++; if (vout.rgb !== 12'h185) begin errors++; $display("FAIL basic_rgb: got %h exp %h", vout.rgb, 12'h185); end
    checks++; if (vout.hcount !== 11'd5) begin errors++; $display("FAIL basic_hcount: got %0d exp 5", vout.hcount); end
    // Distinct pixel every cycle: output must trail input by exactly 3 clocks.
    for (int k = 0; k < 6; k++) begin
      set_pix(11'(10 + k), 11'd100, 1'b0, 1'b0, 12'(12'h400 + k));
      step();
      if (k >= 2) begin
        checks++; if (vout.hcount !== 11'(8 + k)) begin errors++; $display("FAIL lat_hcount%0d: got %0d exp %0d", k, vout.hcount, 8 + k); end
        checks++; if (vout.rgb !== 12'(12'h3FE + k)) begin errors++; $display("FAIL lat_rgb%0d: got %h exp %h", k, vout.rgb, 12'(12'h3FE + k)); end
      end
    end
  endtask

  task automatic test_priority();
    cfg_write(4'd0, mk(1'b1, 5'd0, 11'd239, 11'd0, 11'd640));
    cfg_write(4'd1, mk(1'b1, 5'd0, 11'd250, 11'd100, 11'd200));
    frame_start();
    set_pix(11'd150, 11'd255, 1'b0, 1'b0, 12'h050);
    step();
    checks++; if (pixel_addr !== 11'd1046) begin errors++; $display("FAIL prio_slot0_addr: got %0d exp 1046", pixel_addr); end
    step(); step();
    checks++; if (vout.rgb !== 12'h516) begin errors++; $display("FAIL prio_slot0_rgb: got %h exp %h", vout.rgb, 12'h516); end
    cfg_write(4'd0, mk(1'b0, 5'd0, 11'd239, 11'd0, 11'd640));
    frame_start();
    set_pix(11'd150, 11'd255, 1'b0, 1'b0, 12'h050);
    step();
    checks++; if (pixel_addr !== 11'd370) begin errors++; $display("FAIL prio_slot1_addr: got %0d exp 370", pixel_addr); end
    cfg_write(4'd1, mk(1'b1, 5'd30, 11'd250, 11'd100, 11'd200));
    frame_start();
    set_pix(11'd150, 11'd255, 1'b0, 1'b0, 12'h050);
    step();
    checks++; if (pixel_addr !== 11'd242) begin errors++; $display("FAIL row_off_addr: got %0d exp 242", pixel_addr); end
  endtask

  task automatic test_key();
    key_mode = 1'b1;
    set_pix(11'd150, 11'd255, 1'b0, 1'b0, 12'h123);
    step3();
    checks++; if (vout.rgb !== 12'h123) begin errors++; $display("FAIL key_rgb: got %h exp %h", vout.rgb, 12'h123); end
    set_pix(11'd150, 11'd255, 1'b1, 1'b0, 12'h123);
    step3();
    checks++; if (vout.rgb !== 12'h888) begin errors++; $display("FAIL hblnk_rgb: got %h exp %h", vout.rgb, 12'h888); end
    key_mode = 1'b0;
    start_game = 1'b0;
    set_pix(11'd150, 11'd255, 1'b0, 1'b0, 12'h456);
    step3();
    checks++; if (vout.rgb !== 12'h456) begin errors++; $display("FAIL game_off_rgb: got %h exp %h", vout.rgb, 12'h456); end
    start_game = 1'b1;
    step3();
    checks++; if (vout.rgb !== 12'h1F2) begin errors++; $display("FAIL game_on_rgb: got %h exp %h", vout.rgb, 12'h1F2); end
  endtask

  task automatic test_shadow();
    cfg_write(4'd2, mk(1'b1, 5'd0, 11'd400, 11'd0, 11'd576));
    frame_start();
    set_pix(11'd500, 11'd410, 1'b0, 1'b0, 12'h0AA);
    step3();
    checks++; if (vout.rgb !== 12'h3B4) begin errors++; $display("FAIL shadow_old_rgb: got %h exp %h", vout.rgb, 12'h3B4); end
    cfg_write(4'd2, mk(1'b1, 5'd0, 11'd400, 11'd0, 11'd320));
    step3();
    checks++; if (vout.rgb !== 12'h3B4) begin errors++; $display("FAIL shadow_hold_rgb: got %h exp %h", vout.rgb, 12'h3B4); end
    frame_start();
    set_pix(11'd500, 11'd410, 1'b0, 1'b0, 12'h0AA);
    step3();
    checks++; if (vout.rgb !== 12'h0AA) begin errors++; $display("FAIL shadow_new_rgb: got %h exp %h", vout.rgb, 12'h0AA); end
    // Write coinciding with the vblnk rise must be swapped in immediately.
    vin.vblnk = 1'b1;
    cfg_write(4'd2, mk(1'b1, 5'd0, 11'd400, 11'd0, 11'd576));
    set_pix(11'd500, 11'd410, 1'b0, 1'b0, 12'h0AA);
    step3();
    checks++; if (vout.rgb !== 12'h3B4) begin errors++; $display("FAIL write_through_rgb: got %h exp %h", vout.rgb, 12'h3B4); end
    cfg_write(4'd12, mk(1'b1, 5'd0, 11'd0, 11'd0, 11'd2047));
    frame_start();
    set_pix(11'd10, 11'd10, 1'b0, 1'b0, 12'h0BB);
    step3();
    checks++; if (vout.rgb !== 12'h0BB) begin errors++; $display("FAIL bad_idx_rgb: got %h exp %h", vout.rgb, 12'h0BB); end
  endtask

  task automatic test_edges();
    cfg_write(4'd3, mk(1'b1, 5'd0, 11'd600, 11'd300, 11'd300));
    cfg_write(4'd4, mk(1'b1, 5'd0, 11'd2040, 11'd0, 11'd640));
    cfg_write(4'd5, mk(1'b1, 5'd0, 11'd700, 11'd100, 11'd400));
    frame_start();
    set_pix(11'd300, 11'd605, 1'b0, 1'b0, 12'h0C1);
    step3();
    checks++; if (vout.rgb !== 12'h0C1) begin errors++; $display("FAIL empty_extent: got %h exp %h", vout.rgb, 12'h0C1); end
    set_pix(11'd10, 11'd0, 1'b0, 1'b0, 12'h0C2);
    step3();
    checks++; if (vout.rgb !== 12'h0C2) begin errors++; $display("FAIL nowrap_v0: got %h exp %h", vout.rgb, 12'h0C2); end
    set_pix(11'd10, 11'd7, 1'b0, 1'b0, 12'h0C3);
    step3();
    checks++; if (vout.rgb !== 12'h0C3) begin errors++; $display("FAIL nowrap_v7: got %h exp %h", vout.rgb, 12'h0C3); end
    set_pix(11'd164, 11'd700, 1'b0, 1'b0, 12'h0C7);
    step();
    checks++; if (pixel_addr !== 11'd0) begin errors++; $display("FAIL tile_repeat_addr: got %0d exp 0", pixel_addr); end
    step(); step();
    checks++; if (vout.rgb !== 12'h100) begin errors++; $display("FAIL tile_repeat_rgb: got %h exp %h", vout.rgb, 12'h100); end
    set_pix(11'd165, 11'd731, 1'b0, 1'b0, 12'h0C7);
    step();
    checks++; if (pixel_addr !== 11'd1985) begin errors++; $display("FAIL bottom_row_addr: got %0d exp 1985", pixel_addr); end
    set_pix(11'd399, 11'd700, 1'b0, 1'b0, 12'h0C7);
    step();
    checks++; if (pixel_addr !== 11'd43) begin errors++; $display("FAIL xend_m1_addr: got %0d exp 43", pixel_addr); end
    step(); step();
    checks++; if (vout.rgb !== 12'h12B) begin errors++; $display("FAIL xend_m1_rgb: got %h exp %h", vout.rgb, 12'h12B); end
    set_pix(11'd400, 11'd700, 1'b0, 1'b0, 12'h0C4);
    step3();
    checks++; if (vout.rgb !== 12'h0C4) begin errors++; $display("FAIL xend_miss: got %h exp %h", vout.rgb, 12'h0C4); end
    set_pix(11'd165, 11'd732, 1'b0, 1'b0, 12'h0C5);
    step3();
    checks++; if (vout.rgb !== 12'h0C5) begin errors++; $display("FAIL ybottom_miss: got %h exp %h", vout.rgb, 12'h0C5); end
    set_pix(11'd99, 11'd700, 1'b0, 1'b0, 12'h0C6);
    step3();
    checks++; if (vout.rgb !== 12'h0C6) begin errors++; $display("FAIL xstart_miss: got %h exp %h", vout.rgb, 12'h0C6); end
  endtask

  task automatic test_reset_mid();
    set_pix(11'd164, 11'd700, 1'b0, 1'b0, 12'h0D0);
    step3();
    checks++; if (vout.rgb !== 12'h100) begin errors++; $display("FAIL pre_reset_rgb: got %h exp %h", vout.rgb, 12'h100); end
    rst_n = 1'b0;
    #1;
    checks++; if (vout.rgb !== 12'h000) begin errors++; $display("FAIL async_reset_rgb: got %h exp %h", vout.rgb, 12'h000); end
    checks++; if (vout.hcount !== 11'd0) begin errors++; $display("FAIL async_reset_hcount: got %0d exp 0", vout.hcount); end
    step();
    rst_n = 1'b1;
    set_pix(11'd164, 11'd700, 1'b0, 1'b0, 12'h0D1);
    step3();
    checks++; if (vout.rgb !== 12'h0D1) begin errors++; $display("FAIL post_reset_rgb: got %h exp %h", vout.rgb, 12'h0D1); end
    checks++; if (vout.hcount !== 11'd164) begin errors++; $display("FAIL post_reset_hcount: got %0d exp 164", vout.hcount); end
    frame_start();
    set_pix(11'd164, 11'd700, 1'b0, 1'b0, 12'h0D2);
    step3();
    checks++; if (vout.rgb !== 12'h0D2) begin errors++; $display("FAIL post_reset_off: got %h exp %h", vout.rgb, 12'h0D2); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_priority();
    test_key();
    test_shadow();
    test_edges();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1, "watchdog expired");
  end

endmodule
